// File: rtl/dp_pkg.sv
// Shared definitions for the datapath sequencer.
// Contents:
//   - default widths for the sequencer parameters
//   - sequencer state encoding (Idle/Exec/Resp)
//   - ALUControl codes understood by the 4x32 register-file/ALU datapath
package dp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 4;

  // Idle = 2'd0, Exec = 2'd1, Resp = 2'd2
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } dp_state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/dp_iter_counter.sv
// Loadable iteration down-counter with zero flag.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset (count -> 0)
//   i_load     - load i_load_val (has priority over i_dec)
//   i_load_val - value to load
//   i_dec      - decrement; ignored when the count is already zero
//   o_zero     - count == 0
module dp_iter_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  assign o_zero = (r_count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !o_zero) begin
      // Guarded so the counter can never underflow.
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Command-driven controller for the 4x32 register-file/ALU datapath.
// Accepts one command (op, a1, a2, a3, count, nowrite) over cmd_valid/cmd_ready, executes it
// count+1 times (one datapath iteration per clock), then returns the last result, last Zero
// flag and sticky Overflow over resp_valid/resp_ready.
// Ports:
//   clk, rst                  - clock; asynchronous active-low reset
//   cmd_*                     - command handshake and fields
//   resp_*                    - response handshake and captured result/flags
//   busy                      - not idle
//   dp_wr, dp_alu_ctrl,
//   dp_addr1/2/3              - datapath control (this block is their only driver)
//   dp_result/zero/overflow   - datapath outputs sampled each iteration
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a1,
  input  logic [ADDR_W-1:0] cmd_a2,
  input  logic [ADDR_W-1:0] cmd_a3,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_nowrite,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_ovf,
  output logic              busy,
  output logic              dp_wr,
  output logic [2:0]        dp_alu_ctrl,
  output logic [ADDR_W-1:0] dp_addr1,
  output logic [ADDR_W-1:0] dp_addr2,
  output logic [ADDR_W-1:0] dp_addr3,
  input  logic [DATA_W-1:0] dp_result,
  input  logic              dp_zero,
  input  logic              dp_overflow
);

  dp_state_e r_state;
  dp_state_e w_state_next;

  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_a1;
  logic [ADDR_W-1:0] r_a2;
  logic [ADDR_W-1:0] r_a3;
  logic              r_nowrite;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_ovf;

  logic w_accept;
  logic w_exec;
  logic w_cnt_zero;

  assign w_accept = (r_state == StIdle) && cmd_valid;
  assign w_exec   = (r_state == StExec);

  dp_iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (cmd_count),
    .i_dec      (w_exec),
    .o_zero     (w_cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (cmd_valid)  w_state_next = StExec;
      StExec: if (w_cnt_zero) w_state_next = StResp;
      StResp: if (resp_ready) w_state_next = StIdle;
      default:                w_state_next = StIdle;
    endcase
  end

  // Command latch and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= '0;
      r_a1      <= '0;
      r_a2      <= '0;
      r_a3      <= '0;
      r_nowrite <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= cmd_op;
        r_a1      <= cmd_a1;
        r_a2      <= cmd_a2;
        r_a3      <= cmd_a3;
        r_nowrite <= cmd_nowrite;
        r_ovf     <= 1'b0;
      end
      if (w_exec) begin
        // Sampled on the same edge the register file writes this iteration.
        r_result <= dp_result;
        r_zero   <= dp_zero;
        r_ovf    <= r_ovf | dp_overflow;
      end
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  assign cmd_ready   = rst && (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign resp_valid  = (r_state == StResp);
  assign dp_wr       = w_exec && !r_nowrite;
  assign dp_alu_ctrl = r_op;
  assign dp_addr1    = r_a1;
  assign dp_addr2    = r_a2;
  assign dp_addr3    = r_a3;
  assign resp_result = r_result;
  assign resp_zero   = r_zero;
  assign resp_ovf    = r_ovf;

endmodule

// File: tb/tb_dp_sequencer.sv
module tb_dp_sequencer;
  import dp_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_a1;
  logic [1:0]  cmd_a2;
  logic [1:0]  cmd_a3;
  logic [3:0]  cmd_count;
  logic        cmd_nowrite;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_ovf;
  logic        busy;
  logic        dp_wr;
  logic [2:0]  dp_alu_ctrl;
  logic [1:0]  dp_addr1;
  logic [1:0]  dp_addr2;
  logic [1:0]  dp_addr3;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_ovf;

  int total = 0;
  int bad   = 0;

  dp_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a1      (cmd_a1),
    .cmd_a2      (cmd_a2),
    .cmd_a3      (cmd_a3),
    .cmd_count   (cmd_count),
    .cmd_nowrite (cmd_nowrite),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_ovf    (resp_ovf),
    .busy        (busy),
    .dp_wr       (dp_wr),
    .dp_alu_ctrl (dp_alu_ctrl),
    .dp_addr1    (dp_addr1),
    .dp_addr2    (dp_addr2),
    .dp_addr3    (dp_addr3),
    .dp_result   (m_res),
    .dp_zero     (m_zero),
    .dp_overflow (m_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: 4x32 register file, combinational reads, write on rising edge.
  logic [31:0] rf [4];
  logic        pre_en;
  logic [1:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] m_a;
  logic [31:0] m_b;

  always @(posedge clk) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (dp_wr) rf[dp_addr3] <= m_res;
  end

  always_comb begin
    m_a   = rf[dp_addr1];
    m_b   = rf[dp_addr2];
    m_res = 32'd0;
    m_ovf = 1'b0;
    case (dp_alu_ctrl)
      ALU_ADD: begin
        m_res = m_a + m_b;
        m_ovf = (m_a[31] == m_b[31]) && (m_res[31] != m_a[31]);
      end
      ALU_SUB: begin
        m_res = m_a - m_b;
        m_ovf = (m_a[31] != m_b[31]) && (m_res[31] != m_a[31]);
      end
      ALU_AND: m_res = m_a & m_b;
      ALU_OR:  m_res = m_a | m_b;
      ALU_SLT: m_res = {31'd0, $signed(m_a) < $signed(m_b)};
      default: m_res = 32'd0;
    endcase
    m_zero = (m_res == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                           input logic [1:0] a3, input logic [3:0] cnt, input logic nw);
    cmd_op      = op;
    cmd_a1      = a1;
    cmd_a2      = a2;
    cmd_a3      = a3;
    cmd_count   = cnt;
    cmd_nowrite = nw;
    cmd_valid   = 1'b1;
  endtask

  // Step negedges until resp_valid, counting EXEC cycles and write cycles.
  task automatic wait_resp(input string tag, output int cycles, output int writes);
    int guard;
    cycles = 0;
    writes = 0;
    guard  = 0;
    while (!resp_valid && guard < 40) begin
      cycles++;
      if (dp_wr) writes++;
      @(negedge clk);
      guard++;
    end
    if (!resp_valid) chk($sformatf("%s.timeout", tag), 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        pre_en;
    logic [1:0]  pre_addr;
    logic [31:0] pre_data;
    logic [2:0]  op;
    logic [1:0]  a1;
    logic [1:0]  a2;
    logic [1:0]  a3;
    logic [3:0]  count;
    logic        nowrite;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ovf;
    int          exp_writes;
    logic [1:0]  chk_addr;
    logic [31:0] chk_val;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input string tag);
    int cycles;
    int writes;
    if (v.pre_en) preload(v.pre_addr, v.pre_data);
    @(negedge clk);
    chk($sformatf("%s.cmd_ready", tag), {31'd0, cmd_ready}, 32'd1);
    drive_cmd(v.op, v.a1, v.a2, v.a3, v.count, v.nowrite);
    resp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("%s.alu_ctrl", tag), {29'd0, dp_alu_ctrl}, {29'd0, v.op});
    chk($sformatf("%s.addr3", tag), {30'd0, dp_addr3}, {30'd0, v.a3});
    wait_resp(tag, cycles, writes);
    chk($sformatf("%s.result", tag), resp_result, v.exp_result);
    chk($sformatf("%s.zero", tag), {31'd0, resp_zero}, {31'd0, v.exp_zero});
    chk($sformatf("%s.ovf", tag), {31'd0, resp_ovf}, {31'd0, v.exp_ovf});
    chk($sformatf("%s.writes", tag), writes, v.exp_writes);
    chk($sformatf("%s.exec_cycles", tag), cycles, 32'(v.count) + 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk($sformatf("%s.idle", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s.rf", tag), rf[v.chk_addr], v.chk_val);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;
    int writes;
    int held;
    int stray;

    // Register state carried between vectors starts at R0=1 R1=5 R2=5 R3=0.
    vecs[0] = '{1'b0, 2'd0, 32'd0, ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd0,  1'b0, 32'd1,  1'b0, 1'b0, 1,  2'd3, 32'd1};
    vecs[1] = '{1'b1, 2'd3, 32'd0, ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd4,  1'b0, 32'd5,  1'b0, 1'b0, 5,  2'd3, 32'd5};
    vecs[2] = '{1'b0, 2'd0, 32'd0, ALU_SUB, 2'd1, 2'd2, 2'd0, 4'd0,  1'b1, 32'd0,  1'b1, 1'b0, 0,  2'd0, 32'd1};
    vecs[3] = '{1'b1, 2'd0, 32'h7FFF_FFFF, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'd1, 1'b0, 32'hFFFF_FFFE,
                1'b0, 1'b1, 2, 2'd1, 32'hFFFF_FFFE};
    // Overflows on the first iteration only; the flag must stick.
    vecs[4] = '{1'b1, 2'd1, 32'd5, ALU_ADD, 2'd0, 2'd1, 2'd1, 4'd1,  1'b0, 32'd3,  1'b0, 1'b1, 2,  2'd1, 32'd3};
    vecs[5] = '{1'b1, 2'd0, 32'd1, ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd0,  1'b0, 32'd6,  1'b0, 1'b0, 1,  2'd3, 32'd6};
    vecs[6] = '{1'b1, 2'd3, 32'd0, ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd15, 1'b0, 32'd16, 1'b0, 1'b0, 16, 2'd3, 32'd16};
    vecs[7] = '{1'b0, 2'd0, 32'd0, ALU_AND, 2'd1, 2'd2, 2'd2, 4'd0,  1'b0, 32'd1,  1'b0, 1'b0, 1,  2'd2, 32'd1};
    vecs[8] = '{1'b0, 2'd0, 32'd0, ALU_SUB, 2'd0, 2'd0, 2'd3, 4'd2,  1'b0, 32'd0,  1'b1, 1'b0, 3,  2'd3, 32'd0};
    vecs[9] = '{1'b0, 2'd0, 32'd0, 3'b111,  2'd0, 2'd1, 2'd2, 4'd0,  1'b1, 32'd0,  1'b1, 1'b0, 0,  2'd2, 32'd1};

    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_a1 = 2'd0; cmd_a2 = 2'd0; cmd_a3 = 2'd0;
    cmd_count = 4'd0; cmd_nowrite = 1'b0;
    resp_ready = 1'b0;
    pre_en = 1'b0; pre_addr = 2'd0; pre_data = 32'd0;

    // Reset held for two cycles: everything reads 0.
    repeat (2) @(negedge clk);
    chk("rst.cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.dp_wr", {31'd0, dp_wr}, 32'd0);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_result", resp_result, 32'd0);
    chk("rst.dp_ctrl", {25'd0, dp_alu_ctrl, dp_addr1, dp_addr2}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.ready_after", {31'd0, cmd_ready}, 32'd1);

    preload(2'd0, 32'd1);
    preload(2'd1, 32'd5);
    preload(2'd2, 32'd5);
    preload(2'd3, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    // Now R0=1 R1=3 R2=1 R3=0.

    // Backpressure: response held while a new command waits.
    @(negedge clk);
    drive_cmd(ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd0, 1'b0);
    @(negedge clk);
    drive_cmd(ALU_OR, 2'd1, 2'd2, 2'd2, 4'd0, 1'b0);
    wait_resp("bp", cycles, writes);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid && !cmd_ready && !dp_wr && busy && resp_result == 32'd1) held++;
      @(negedge clk);
    end
    chk("bp.held_cycles", held, 32'd10);
    chk("bp.rf_untouched", rf[2], 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp.idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp.idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp.accepted", {31'd0, busy}, 32'd1);
    chk("bp.new_ctrl", {27'd0, dp_alu_ctrl, dp_addr3}, {27'd0, ALU_OR, 2'd2});
    wait_resp("bp2", cycles, writes);
    chk("bp2.result", resp_result, 32'd3);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp2.rf", rf[2], 32'd3);

    // Minimum round trip with resp_ready held high: accept -> EXEC -> RESP -> IDLE.
    @(negedge clk);
    drive_cmd(ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd0, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rt.exec_wr", {30'd0, busy, dp_wr}, 32'd3);
    @(negedge clk);
    chk("rt.resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("rt.result", resp_result, 32'd2);
    @(negedge clk);
    chk("rt.idle", {30'd0, cmd_ready, busy}, 32'd2);
    resp_ready = 1'b0;

    // Reset in the middle of a long command.
    preload(2'd3, 32'd0);
    @(negedge clk);
    drive_cmd(ALU_ADD, 2'd0, 2'd3, 2'd3, 4'd7, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid.pre_wr", {31'd0, dp_wr}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid.async_wr", {31'd0, dp_wr}, 32'd0);
    chk("mid.async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || dp_wr || busy) stray++;
    end
    chk("mid.no_activity", stray, 32'd0);
    chk("mid.ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid.rf", rf[3], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Command-driven controller that sequences the 4x32 register-file/ALU datapath: it accepts one ALU command at a time over a valid/ready handshake and drives the datapath address, ALU-control and write-enable ports.
- It repeats the operation a programmable number of times, for example repeated accumulate R3 <- R0 + R3.
- It captures the final result and flags and returns them over a valid/ready response handshake.
- It sits between a host/testbench command source and the datapath, and is the only driver of the datapath control inputs.

Parameters:
DATA_W, 32, datapath word width
ADDR_W, 2, register address width (4 registers)
CNT_W, 4, iteration count width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  ALUControl code, passed through unchanged
cmd_a1  in  ADDR_W  source register A
cmd_a2  in  ADDR_W  source register B
cmd_a3  in  ADDR_W  destination register
cmd_count  in  CNT_W  iterations minus one (0 = execute once)
cmd_nowrite  in  1  1 = compare-only, never assert dp_wr
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_result  out  DATA_W  result of final iteration
resp_zero  out  1  Zero flag of final iteration
resp_ovf  out  1  OR of Overflow over all iterations (sticky)
busy  out  1  high in any state other than IDLE
dp_wr  out  1  datapath write enable
dp_alu_ctrl  out  3  datapath ALUControl
dp_addr1  out  ADDR_W  datapath read address 1
dp_addr2  out  ADDR_W  datapath read address 2
dp_addr3  out  ADDR_W  datapath write address
dp_result  in  DATA_W  datapath Result
dp_zero  in  1  datapath Zero
dp_overflow  in  1  datapath Overflow

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0, iteration counter 0, command registers 0. dp_wr drops immediately, with no clock needed.
- Reset mid-EXEC abandons the command. No further writes occur and no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On a rising edge with cmd_valid=1: latch op/a1/a2/a3/nowrite, counter <- cmd_count, clear sticky ovf, go to EXEC.
- EXEC:
  - cmd_ready=0.
  - dp_alu_ctrl/dp_addr1..3 come from the latched registers and are stable for the whole state.
  - dp_wr = ~nowrite. dp_wr is decoded from state, so it is never high outside EXEC.
  - Each clock in EXEC is one iteration: the register file writes on that edge.
  - On the same edge, sample dp_result, dp_zero and dp_overflow into the response registers, and OR dp_overflow into ovf.
  - If counter==0 go to RESP, else decrement counter.
  - Total EXEC cycles = cmd_count+1.
- RESP:
  - resp_valid=1. resp_result/zero/ovf are held constant.
  - On an edge with resp_ready=1, go to IDLE.
  - cmd_valid is ignored until back in IDLE. There is no RESP->EXEC bypass.
- Latency:
  - Command accept edge -> first write edge = 1 cycle.
  - resp_valid rises the cycle after the last write edge.
  - Minimum round trip from accept to IDLE is 3 edges when resp_ready is held high.
- a3 equal to a1 or a2 is legal. Each iteration uses the value written by the previous one, because the datapath reads combinationally.
- Counter wrap: cmd_count = 2^CNT_W-1 gives 16 iterations. The counter never underflows.
- cmd_op is not decoded. Illegal codes pass through and the datapath defines the result.
- busy = (state != IDLE).

Decomposition:
- Shared package dp_pkg holds:
  - state encoding constants (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - ALU op constants (ALU_ADD=3'b000, etc.) for benches;
  - DATA_W/ADDR_W defaults.
- One natural sub-module, dp_iter_counter: loadable down-counter with a zero flag. Everything else stays flat.

Test Plan:
- The bench datapath model is preloaded with R0=1, R1=5, R2=5, R3=0.
- Reset: hold rst=0 for 2 cycles, then pulse rst=0 for one cycle mid-EXEC -> all outputs 0, cmd_ready=1 after release, dp_wr=0 immediately, no resp_valid.
- Single add: op=000, a1=0, a2=3, a3=3, count=0 -> exactly 1 cycle with dp_wr=1; resp_result=1, R3=1, resp_zero=0, resp_ovf=0.
- Iterated accumulate: same command with count=4 -> 5 consecutive dp_wr cycles; R3 goes 1,2,3,4,5; resp_result=5.
- Compare-only: op=subtract, a1=1, a2=2, nowrite=1 -> dp_wr never high; resp_zero=1; R1 and R2 unchanged.
- Sticky overflow: R0=32'h7FFFFFFF, add R0+R0 into R1 with count=1 -> first iteration overflows; resp_ovf=1 even if the last iteration does not overflow.
- Backpressure: hold resp_ready=0 for 10 cycles while cmd_valid=1 -> resp held stable, cmd_ready=0 and the new command is not taken. After resp_ready=1, return to IDLE and the command is accepted on the next edge.
